fetch_controller: RTL and testbench

//  Sequences the combinational byte-addressed instruction memory. Owns the PC and drives instructionAddress.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_perf_counter.sv | 29 ++
 rtl/fetch_controller.sv | 118 +++++++++++
 tb/tb_fetch_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction fetch controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_perf_counter.sv
// ============================================================================
// Module  : fetch_perf_counter
// Brief   : Saturating up-counter with enable; sticks at all-ones.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module  : fetch_controller
// Brief   : PC sequencer with one-entry registered output slot, redirect and
//           halt-sentinel handling. Optional macro FETCH_PERF_COUNTERS_EN adds
//           fetchCount / stallCount saturating counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    output logic        fetchValid,
    input  logic        fetchReady,
    output logic [31:0] fetchInstr,
    output logic [31:0] fetchPC,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        halted,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount,
`endif
    output logic        misaligned
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         slot_free;
    logic         redirect_bad;

    assign instructionAddress = pc;
    assign halted             = (state == HALT);
    assign slot_free          = !fetchValid || fetchReady;
    assign redirect_bad       = redirectValid && (redirectTarget[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            fetchValid <= 1'b0;
            fetchInstr <= '0;
            fetchPC    <= '0;
            misaligned <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect_bad) begin
                        state      <= FAULT;
                        misaligned <= 1'b1;
                        fetchValid <= 1'b0;
                    end else if (redirectValid) begin
                        // Any unaccepted slot belongs to the wrong path; drop it.
                        pc         <= redirectTarget;
                        fetchValid <= 1'b0;
                    end else if (slot_free && (instruction == HALT_WORD)) begin
                        state      <= HALT;
                        fetchValid <= 1'b0;
                    end else if (slot_free) begin
                        fetchInstr <= instruction;
                        fetchPC    <= pc;
                        fetchValid <= 1'b1;
                        pc         <= pc + INSTR_BYTES;
                    end
                end
                HALT: begin
                    fetchValid <= 1'b0;
                    if (redirect_bad) begin
                        state      <= FAULT;
                        misaligned <= 1'b1;
                    end else if (redirectValid) begin
                        state <= RUN;
                        pc    <= redirectTarget;
                    end
                end
                FAULT: begin
                    fetchValid <= 1'b0;
                end
                default: begin
                    state      <= FAULT;
                    fetchValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic fetch_en;
    logic stall_en;

    assign fetch_en = fetchValid && fetchReady;
    assign stall_en = (state == RUN) && fetchValid && !fetchReady;

    fetch_perf_counter #(.WIDTH(32)) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fetch_en),
        .count (fetchCount)
    );

    fetch_perf_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .count (stallCount)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module  : tb_fetch_controller
// Brief   : Directed self-checking bench for fetch_controller (both builds of
//           FETCH_PERF_COUNTERS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        ready, ready2;
    logic        redir_valid;
    logic [31:0] redir_target;

    logic [31:0] addr_a, instr_a, finstr_a, fpc_a;
    logic        fvalid_a, halted_a, misal_a;
    logic [31:0] addr_b, instr_b, finstr_b, fpc_b;
    logic        fvalid_b, halted_b, misal_b;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fcnt_a, scnt_a, fcnt_b, scnt_b;
`endif

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    assign instr_a = rd_word(addr_a);
    assign instr_b = rd_word(addr_b);

    fetch_controller u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instructionAddress (addr_a),
        .instruction        (instr_a),
        .fetchValid         (fvalid_a),
        .fetchReady         (ready),
        .fetchInstr         (finstr_a),
        .fetchPC            (fpc_a),
        .redirectValid      (redir_valid),
        .redirectTarget     (redir_target),
        .halted             (halted_a),
`ifdef FETCH_PERF_COUNTERS_EN
        .fetchCount         (fcnt_a),
        .stallCount         (scnt_a),
`endif
        .misaligned         (misal_a)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk                (clk),
        .rst_n              (rst2_n),
        .instructionAddress (addr_b),
        .instruction        (instr_b),
        .fetchValid         (fvalid_b),
        .fetchReady         (ready2),
        .fetchInstr         (finstr_b),
        .fetchPC            (fpc_b),
        .redirectValid      (1'b0),
        .redirectTarget     (32'h0),
        .halted             (halted_b),
`ifdef FETCH_PERF_COUNTERS_EN
        .fetchCount         (fcnt_b),
        .stallCount         (scnt_b),
`endif
        .misaligned         (misal_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put_word(input logic [7:0] a, input logic [31:0] w);
        mem[a]        = w[7:0];
        mem[a + 8'd1] = w[15:8];
        mem[a + 8'd2] = w[23:16];
        mem[a + 8'd3] = w[31:24];
    endtask

    // Advance one edge; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i += 4) put_word(i[7:0], 32'h1000_0000 | i);
        put_word(8'h18, 32'hFFFF_FFFF);

        rst_n = 1'b0; rst2_n = 1'b0;
        ready = 1'b1; ready2 = 1'b1;
        redir_valid = 1'b0; redir_target = 32'h0;

        @(negedge clk);
        check_eq("rst_valid",  {31'b0, fvalid_a}, 32'd0);
        check_eq("rst_addr",   addr_a, 32'h0);
        check_eq("rst_instr",  finstr_a, 32'h0);
        check_eq("rst_pc",     fpc_a, 32'h0);
        check_eq("rst_halted", {31'b0, halted_a}, 32'd0);
        check_eq("rst_misal",  {31'b0, misal_a}, 32'd0);
        rst_n = 1'b1;

        // Streaming fetch
        step();
        check_eq("t1_valid0", {31'b0, fvalid_a}, 32'd1);
        check_eq("t1_pc0",    fpc_a, 32'h0);
        check_eq("t1_instr0", finstr_a, 32'h1000_0000);
        step();
        check_eq("t1_pc4",    fpc_a, 32'h4);
        check_eq("t1_instr4", finstr_a, 32'h1000_0004);

        // Back-pressure
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t2_hold_pc",    fpc_a, 32'h4);
            check_eq("t2_hold_instr", finstr_a, 32'h1000_0004);
            check_eq("t2_hold_addr",  addr_a, 32'h8);
        end
        ready = 1'b1;
        step();
        check_eq("t2_pc8",    fpc_a, 32'h8);
        check_eq("t2_instr8", finstr_a, 32'h1000_0008);
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("t2_stalls",  scnt_a, 32'd3);
        check_eq("t2_fetches", fcnt_a, 32'd2);
`endif

        // Redirect discarding a stalled slot
        ready = 1'b0; redir_valid = 1'b1; redir_target = 32'h40;
        step();
        check_eq("t3_drop_valid", {31'b0, fvalid_a}, 32'd0);
        check_eq("t3_drop_addr",  addr_a, 32'h40);
        redir_valid = 1'b0; ready = 1'b1;
        step();
        check_eq("t3_pc40",    fpc_a, 32'h40);
        check_eq("t3_instr40", finstr_a, 32'h1000_0040);
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("t3_fetches_drop", fcnt_a, 32'd2);
`endif
        // Redirect coinciding with a transfer
        redir_valid = 1'b1; redir_target = 32'h40;
        step();
        check_eq("t3_xfer_valid", {31'b0, fvalid_a}, 32'd0);
        redir_valid = 1'b0;
        step();
        check_eq("t3_pc40_again", fpc_a, 32'h40);
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("t3_fetches_xfer", fcnt_a, 32'd3);
`endif

        // Halt sentinel at 0x18
        redir_valid = 1'b1; redir_target = 32'h10;
        step();
        redir_valid = 1'b0;
        step();
        check_eq("t4_pc10", fpc_a, 32'h10);
        step();
        check_eq("t4_pc14", fpc_a, 32'h14);
        step();
        check_eq("t4_halted",   {31'b0, halted_a}, 32'd1);
        check_eq("t4_valid",    {31'b0, fvalid_a}, 32'd0);
        check_eq("t4_addr",     addr_a, 32'h18);
        check_eq("t4_last_pc",  fpc_a, 32'h14);
        step();
        check_eq("t4_still_halted", {31'b0, halted_a}, 32'd1);
        redir_valid = 1'b1; redir_target = 32'h0;
        step();
        redir_valid = 1'b0;
        check_eq("t4_unhalt", {31'b0, halted_a}, 32'd0);
        step();
        check_eq("t4_resume_pc",    fpc_a, 32'h0);
        check_eq("t4_resume_valid", {31'b0, fvalid_a}, 32'd1);

        // Misaligned redirect -> FAULT
        redir_valid = 1'b1; redir_target = 32'h42;
        step();
        check_eq("t5_misal", {31'b0, misal_a}, 32'd1);
        check_eq("t5_valid", {31'b0, fvalid_a}, 32'd0);
        check_eq("t5_addr",  addr_a, 32'h4);
        redir_target = 32'h40;
        step();
        redir_valid = 1'b0;
        check_eq("t5_ignored_addr", addr_a, 32'h4);
        check_eq("t5_sticky",       {31'b0, misal_a}, 32'd1);
        step();
        check_eq("t5_fault_valid", {31'b0, fvalid_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_misal", {31'b0, misal_a}, 32'd0);
        check_eq("t5_rst_addr",  addr_a, 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("t5_restart_pc",    fpc_a, 32'h0);
        check_eq("t5_restart_valid", {31'b0, fvalid_a}, 32'd1);

        // Wrap-around from RESET_PC = 0xFFFFFFFC and async clear mid-stall
        check_eq("t6_rst_addr", addr_b, 32'hFFFF_FFFC);
        rst2_n = 1'b1;
        step();
        check_eq("t6_pc_top",    fpc_b, 32'hFFFF_FFFC);
        check_eq("t6_instr_top", finstr_b, 32'h1000_00FC);
        check_eq("t6_addr_wrap", addr_b, 32'h0);
        step();
        check_eq("t6_pc_wrap",    fpc_b, 32'h0);
        check_eq("t6_instr_wrap", finstr_b, 32'h1000_0000);
        ready2 = 1'b0;
        step();
        check_eq("t6_stall_valid", {31'b0, fvalid_b}, 32'd1);
        rst2_n = 1'b0;
        #1;
        check_eq("t6_async_valid", {31'b0, fvalid_b}, 32'd0);
        check_eq("t6_async_addr",  addr_b, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("t6_async_scnt", scnt_b, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
